// File: rtl/banco_regs_pkg.sv
// banco_regs_pkg: shared flag-mode encoding and bit-position helpers for the register bank.
package banco_regs_pkg;
    typedef enum logic {
        FLAG_MODE_MERGE = 1'b0,
        FLAG_MODE_W1C   = 1'b1
    } flag_mode_e;

    // GO sits just above the flags; interrupt enables start one bit above GO.
    function automatic int go_bit(int flag_w);
        return flag_w;
    endfunction

    function automatic int irqen_base(int flag_w);
        return flag_w + 1;
    endfunction
endpackage

// File: rtl/banco_registros_control_reg_celda.sv
// reg_celda: one control/status register with byte-strobed writes, sticky flags and optional GO clear.
module reg_celda
    import banco_regs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FLAG_W    = 2,
    parameter int FLAG_MODE = 0,
    parameter bit GO_EN     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] strb,
    input  logic [DATA_W-1:0]   wd,
    input  logic [FLAG_W-1:0]   hs,
    input  logic                go_clr,
    output logic [DATA_W-1:0]   q
);
    localparam int GO_BIT = go_bit(FLAG_W);
    localparam bit W1C    = FLAG_MODE == int'(FLAG_MODE_W1C);

    logic [DATA_W-1:0] mask, d;
    logic [FLAG_W-1:0] f_base;

    always_comb begin
        mask = '0;
        for (int b = 0; b < DATA_W; b++) mask[b] = we & strb[b/8];
        d = (q & ~mask) | (wd & mask);
        f_base = (we & strb[0]) ? (W1C ? q[FLAG_W-1:0] & ~wd[FLAG_W-1:0] : wd[FLAG_W-1:0])
                                : q[FLAG_W-1:0];
        // hw_set is OR-ed last so it always beats a same-cycle clear
        d[FLAG_W-1:0] = f_base | hs;
        if (GO_EN && go_clr && !mask[GO_BIT]) d[GO_BIT] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end
endmodule

// File: rtl/banco_registros_control.sv
// banco_registros_control: bank of N_REGS control/status registers with GO handshake,
// registered read port and masked interrupt.
module banco_registros_control
    import banco_regs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int N_REGS    = 4,
    parameter int FLAG_W    = 2,
    parameter int FLAG_MODE = 0,
    parameter int ADDR_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_strb,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    input  logic [N_REGS*FLAG_W-1:0] hw_set,
    input  logic                     done_i,
    output logic                     go_o,
    output logic                     irq_o
);
    localparam int GO_BIT     = go_bit(FLAG_W);
    localparam int IRQEN_BASE = irqen_base(FLAG_W);
    localparam int EN_REG     = (N_REGS > 1) ? 1 : 0;

    logic [DATA_W-1:0] regs [N_REGS];
    logic              irq_d;

    // Out-of-range write addresses match no cell, so they fall away here
    for (genvar g = 0; g < N_REGS; g++) begin : g_celda
        reg_celda #(
            .DATA_W   (DATA_W),
            .FLAG_W   (FLAG_W),
            .FLAG_MODE(FLAG_MODE),
            .GO_EN    (g == 0)
        ) u_celda (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en && int'(wr_addr) == g),
            .strb  (wr_strb),
            .wd    (wr_data),
            .hs    (hw_set[g*FLAG_W +: FLAG_W]),
            .go_clr(done_i),
            .q     (regs[g])
        );
    end

    assign go_o = regs[0][GO_BIT];

    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < N_REGS; i++)
            irq_d |= (|regs[i][FLAG_W-1:0]) & regs[EN_REG][IRQEN_BASE+i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            irq_o   <= 1'b0;
        end else begin
            rd_data <= (int'(rd_addr) < N_REGS) ? regs[rd_addr] : '0;
            irq_o   <= irq_d;
        end
    end
endmodule

// File: tb/tb_banco_registros_control.sv
// tb_banco_registros_control: directed and random checks of two bank configurations
// (4 regs merge mode, 3 regs W1C mode) against a behavioural model.
module tb_banco_registros_control;
    logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, done_i = 1'b0;
    logic [1:0]  wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic [7:0]  hw_set = '0;
    logic [31:0] rd_a, rd_b;
    logic        go_a, go_b, irq_a, irq_b;

    int errors = 0, checks = 0;
    logic [31:0] m [2][4];
    logic [31:0] mrd [2];
    logic        mirq [2];

    always #5 clk = ~clk;

    banco_registros_control #(.DATA_W(32), .N_REGS(4), .FLAG_W(2), .FLAG_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .rd_addr(rd_addr), .rd_data(rd_a), .hw_set(hw_set),
        .done_i(done_i), .go_o(go_a), .irq_o(irq_a)
    );

    banco_registros_control #(.DATA_W(32), .N_REGS(3), .FLAG_W(2), .FLAG_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .rd_addr(rd_addr), .rd_data(rd_b), .hw_set(hw_set[5:0]),
        .done_i(done_i), .go_o(go_b), .irq_o(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) m[d][i] = '0;
            mrd[d] = '0;
            mirq[d] = 1'b0;
        end
    endtask

    // Advance one clock: model computes the next state from the current inputs, then compare.
    task automatic step();
        logic [31:0] n [2][4];
        logic [31:0] nrd [2];
        logic        nirq [2];
        n = m;
        for (int d = 0; d < 2; d++) begin
            int nr;
            nr = (d == 0) ? 4 : 3;
            for (int i = 0; i < nr; i++) begin
                logic [1:0] f;
                logic       hit;
                hit = wr_en && int'(wr_addr) == i;
                f = m[d][i][1:0];
                for (int k = 0; k < 4; k++)
                    if (hit && wr_strb[k]) n[d][i][8*k +: 8] = wr_data[8*k +: 8];
                if (hit && wr_strb[0]) f = (d == 1) ? (f & ~wr_data[1:0]) : wr_data[1:0];
                n[d][i][1:0] = f | hw_set[2*i +: 2];
            end
            if (done_i && !(wr_en && wr_addr == 2'd0 && wr_strb[0])) n[d][0][2] = 1'b0;
            nrd[d] = (int'(rd_addr) < nr) ? m[d][rd_addr] : 32'h0;
            nirq[d] = 1'b0;
            for (int i = 0; i < nr; i++) nirq[d] |= (|m[d][i][1:0]) & m[d][1][3+i];
        end
        @(posedge clk);
        #1;
        m = n;
        mrd = nrd;
        mirq = nirq;
        check("rd_a", rd_a, mrd[0]);
        check("go_a", {31'b0, go_a}, {31'b0, m[0][0][2]});
        check("irq_a", {31'b0, irq_a}, {31'b0, mirq[0]});
        check("rd_b", rd_b, mrd[1]);
        check("go_b", {31'b0, go_b}, {31'b0, m[1][0][2]});
        check("irq_b", {31'b0, irq_b}, {31'b0, mirq[1]});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] dat, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = dat; wr_strb = s;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_strb = '0; hw_set = '0; done_i = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_go_a", {31'b0, go_a}, 32'h0);
        check("reset_irq_a", {31'b0, irq_a}, 32'h0);
        check("reset_rd_b", rd_b, 32'h0);
        rst = 1'b0;

        // Reset mid-operation
        wr(2'd0, 32'hFFFF_FFFF, 4'hF); step();
        wr(2'd1, 32'hFFFF_FFFF, 4'hF); rd_addr = 2'd0; step();
        idle(); step();
        check("pre_rst_go", {31'b0, go_a}, 32'h1);
        check("pre_rst_irq", {31'b0, irq_a}, 32'h1);
        check("pre_rst_rd", rd_a, 32'hFFFF_FFFF);
        #3 rst = 1'b1;
        #1;
        check("async_rst_rd", rd_a, 32'h0);
        check("async_rst_go", {31'b0, go_a}, 32'h0);
        check("async_rst_irq", {31'b0, irq_a}, 32'h0);
        check("async_rst_go_b", {31'b0, go_b}, 32'h0);
        model_clear();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); step();
        end

        // Byte strobes
        wr(2'd2, 32'hAABB_CCDD, 4'b0101); step();
        idle(); rd_addr = 2'd2; step();
        step();
        check("strobe_merge", rd_a, 32'h00BB_00DD);

        // W1C on dut_b reg2 (merge on dut_a alongside)
        hw_set = 8'b0011_0000; step();
        idle(); wr(2'd2, 32'h1, 4'hF); step();
        idle(); step();
        step();
        check("w1c_clear", rd_b, 32'h2);
        hw_set = 8'b0011_0000; step();
        idle(); wr(2'd2, 32'h1, 4'hF); hw_set = 8'b0001_0000; step();
        idle(); step();
        step();
        check("w1c_hw_wins", rd_b, 32'h3);

        // GO handshake
        wr(2'd0, 32'h4, 4'b0001); step();
        check("go_set", {31'b0, go_a}, 32'h1);
        idle(); step();
        check("go_hold", {31'b0, go_a}, 32'h1);
        done_i = 1'b1; step();
        check("go_done", {31'b0, go_a}, 32'h0);
        wr(2'd0, 32'h4, 4'b0001); done_i = 1'b1; step();
        check("go_write_wins", {31'b0, go_a}, 32'h1);
        idle(); wr(2'd0, 32'h0, 4'b0001); step();
        check("go_abort", {31'b0, go_a}, 32'h0);

        // Interrupt path
        wr(2'd1, 32'h8, 4'b0001); step();
        idle(); hw_set = 8'h01; step();
        check("irq_latency0", {31'b0, irq_a}, 32'h0);
        idle(); step();
        check("irq_raise", {31'b0, irq_a}, 32'h1);
        wr(2'd1, 32'h0, 4'b0001); step();
        idle(); step();
        check("irq_disable", {31'b0, irq_a}, 32'h0);

        // Out-of-range address on the 3-register bank
        wr(2'd3, 32'hFFFF_FFFF, 4'hF); step();
        idle(); rd_addr = 2'd3; step();
        step();
        check("oor_read_b", rd_b, 32'h0);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 2'(i); step();
        end

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            wr_strb = 4'($urandom);
            rd_addr = 2'($urandom_range(0, 3));
            hw_set  = 8'($urandom & $urandom & $urandom);
            done_i  = ($urandom_range(0, 7) == 0);
            step();
        end
        idle(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
